// File: rtl/scanline_sync_fx.sv
// scanline_sync_fx: post-mixer video stage. Measures HSync/VSync polarity and
// presents both as active-high. Tracks line parity inside each frame, darkens
// odd lines by a selectable amount, and forces RGB to black during blanking.
// Every output is registered once per ce_pix sample.
module scanline_sync_fx #(
    parameter int CNT_W = 12
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [1:0]       scanlines,
    input  logic [7:0]       R_in,
    input  logic [7:0]       G_in,
    input  logic [7:0]       B_in,
    input  logic             HSync_in,
    input  logic             VSync_in,
    input  logic             HBlank_in,
    input  logic             VBlank_in,
    output logic [7:0]       R_out,
    output logic [7:0]       G_out,
    output logic [7:0]       B_out,
    output logic             HSync_out,
    output logic             VSync_out,
    output logic             HBlank_out,
    output logic             VBlank_out,
    output logic             line_odd
);

    // Polarity measurement state
    logic [CNT_W-1:0] h_hi, h_lo, v_hi, v_lo;
    logic [CNT_W-1:0] h_hi_d, h_lo_d, v_hi_d, v_lo_d;
    logic             h_pol, v_pol, h_pol_d, v_pol_d;

    // Raw and normalised edge-detect history
    logic             hs_raw_q, vs_raw_q;
    logic             hs_n_q, vs_n_q;

    // Per-sample combinational results
    logic             h_rise, v_rise;
    logic             hs_n, vs_n;
    logic             hs_edge, vs_edge;
    logic             odd_d;
    logic [7:0]       r_d, g_d, b_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Mode 0 leaves the channel untouched, so the caller only gates on parity.
    function automatic logic [7:0] darken(input logic [7:0] c, input logic [1:0] mode);
        case (mode)
            2'd1:    return c - (c >> 2);
            2'd2:    return c >> 1;
            2'd3:    return c >> 2;
            default: return c;
        endcase
    endfunction

    // Next-state: polarity counters, normalised sync, parity and colour.
    always_comb begin
        h_rise  = HSync_in & ~hs_raw_q;
        v_rise  = VSync_in & ~vs_raw_q;

        h_pol_d = h_pol;
        h_hi_d  = h_hi;
        h_lo_d  = h_lo;
        if (h_rise) begin
            h_pol_d = (h_hi > h_lo);
            // The edge sample itself starts the new high period.
            h_hi_d  = CNT_W'(1);
            h_lo_d  = '0;
        end else if (HSync_in) begin
            h_hi_d  = sat_inc(h_hi);
        end else begin
            h_lo_d  = sat_inc(h_lo);
        end

        v_pol_d = v_pol;
        v_hi_d  = v_hi;
        v_lo_d  = v_lo;
        if (v_rise) begin
            v_pol_d = (v_hi > v_lo);
            v_hi_d  = '0;
            v_lo_d  = '0;
        end
        // A line start on the same sample as a VSync edge counts into the new frame.
        if (h_rise) begin
            if (VSync_in) v_hi_d = sat_inc(v_hi_d);
            else          v_lo_d = sat_inc(v_lo_d);
        end

        hs_n    = HSync_in ^ h_pol_d;
        vs_n    = VSync_in ^ v_pol_d;
        // A polarity flip reloads the detector instead of producing an edge.
        hs_edge = hs_n & ~hs_n_q & (h_pol_d == h_pol);
        vs_edge = vs_n & ~vs_n_q & (v_pol_d == v_pol);

        odd_d = line_odd;
        if (vs_edge)      odd_d = 1'b0;
        else if (hs_edge) odd_d = ~line_odd;

        r_d = R_in;
        g_d = G_in;
        b_d = B_in;
        if (HBlank_in || VBlank_in) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else if (odd_d) begin
            r_d = darken(R_in, scanlines);
            g_d = darken(G_in, scanlines);
            b_d = darken(B_in, scanlines);
        end
    end

    // Single pixel-enable register stage for all state and outputs.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            h_hi       <= '0;
            h_lo       <= '0;
            v_hi       <= '0;
            v_lo       <= '0;
            h_pol      <= 1'b0;
            v_pol      <= 1'b0;
            hs_raw_q   <= 1'b0;
            vs_raw_q   <= 1'b0;
            hs_n_q     <= 1'b0;
            vs_n_q     <= 1'b0;
            line_odd   <= 1'b0;
            R_out      <= '0;
            G_out      <= '0;
            B_out      <= '0;
            HSync_out  <= 1'b0;
            VSync_out  <= 1'b0;
            HBlank_out <= 1'b0;
            VBlank_out <= 1'b0;
        end else if (ce_pix) begin
            h_hi       <= h_hi_d;
            h_lo       <= h_lo_d;
            v_hi       <= v_hi_d;
            v_lo       <= v_lo_d;
            h_pol      <= h_pol_d;
            v_pol      <= v_pol_d;
            hs_raw_q   <= HSync_in;
            vs_raw_q   <= VSync_in;
            hs_n_q     <= hs_n;
            vs_n_q     <= vs_n;
            line_odd   <= odd_d;
            R_out      <= r_d;
            G_out      <= g_d;
            B_out      <= b_d;
            HSync_out  <= hs_n;
            VSync_out  <= vs_n;
            HBlank_out <= HBlank_in;
            VBlank_out <= VBlank_in;
        end
    end

endmodule
